// File: rtl/imem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// response-owner state encoding, default geometry and small helpers.
package imem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF     = 6;
  localparam int unsigned STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RESP_IF = 2'b01,
    ST_RESP_DM = 2'b10
  } arb_state_e;

  function automatic logic misaligned(input logic [1:0] byte_off);
    return (byte_off != 2'b00);
  endfunction

endpackage

// File: rtl/imem_starve_counter.sv
// Counts consecutive cycles in which a pending fetch was denied and
// raises force_if_o once the count reaches STARVE_MAX.
module imem_starve_counter
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic force_if_o
);

  localparam logic [1:0] CNT_SAT = 2'(STARVE_MAX);

  logic [1:0] cnt_q;
  logic [1:0] cnt_d;

  // Next count: saturating increment on a denied fetch, otherwise clear.
  always_comb begin
    cnt_d = 2'd0;
    if (if_req_i && !if_gnt_i) begin
      if (cnt_q >= CNT_SAT) begin
        cnt_d = CNT_SAT;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end else begin
      cnt_d = 2'd0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if_o = (cnt_q >= CNT_SAT);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one single-ported word memory between instruction fetch and the
// load/store path; data wins ties unless fetch has starved too long.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  output logic              stall_if_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [3:0]        dm_be_i,
  input  logic [31:0]       dm_addr_i,
  input  logic [31:0]       dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [31:0]       dm_rdata_o,
  output logic              dm_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  logic        force_if_s;
  logic        if_gnt_s;
  logic        dm_gnt_s;
  logic        misalign_s;
  arb_state_e  state_q;
  arb_state_e  state_d;
  logic [31:0] if_rdata_q;
  logic [31:0] dm_rdata_q;
  logic        dm_err_q;
  logic        unused_addr_s;

  imem_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .if_req_i   (if_req_i),
    .if_gnt_i   (if_gnt_s),
    .force_if_o (force_if_s)
  );

  assign misalign_s = misaligned(dm_addr_i[1:0]);
  assign dm_gnt_s   = dm_req_i & ~(if_req_i & force_if_s);
  assign if_gnt_s   = if_req_i & ~dm_gnt_s;

  assign if_gnt_o    = if_gnt_s;
  assign dm_gnt_o    = dm_gnt_s;
  assign stall_if_o  = if_req_i & ~if_gnt_s;
  assign mem_we_o    = dm_gnt_s & dm_we_i & ~misalign_s;
  assign mem_be_o    = dm_be_i;
  assign mem_wdata_o = dm_wdata_i;

  // Upper byte-address bits fall outside the memory and wrap away.
  assign unused_addr_s = ^{if_addr_i[31:ADDR_W+2], dm_addr_i[31:ADDR_W+2]};

  // Word address of the granted requester.
  always_comb begin
    mem_addr_o = {ADDR_W{1'b0}};
    if (if_gnt_s) begin
      mem_addr_o = if_addr_i[ADDR_W+1:2];
    end else if (dm_gnt_s) begin
      mem_addr_o = dm_addr_i[ADDR_W+1:2];
    end else begin
      mem_addr_o = {ADDR_W{1'b0}};
    end
  end

  // Next response owner follows this cycle's grant.
  always_comb begin
    state_d = ST_IDLE;
    if (if_gnt_s) begin
      state_d = ST_RESP_IF;
    end else if (dm_gnt_s) begin
      state_d = ST_RESP_DM;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // Response valids decoded from the registered owner.
  always_comb begin
    if_rvalid_o = 1'b0;
    dm_rvalid_o = 1'b0;
    case (state_q)
      ST_RESP_IF: if_rvalid_o = 1'b1;
      ST_RESP_DM: dm_rvalid_o = 1'b1;
      default: begin
        if_rvalid_o = 1'b0;
        dm_rvalid_o = 1'b0;
      end
    endcase
  end

  // State and captured read data; stores answer with a zero word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      if_rdata_q <= 32'h0;
      dm_rdata_q <= 32'h0;
      dm_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (if_gnt_s) begin
        if_rdata_q <= mem_rdata_i;
      end
      if (dm_gnt_s) begin
        dm_rdata_q <= dm_we_i ? 32'h0 : mem_rdata_i;
      end
      dm_err_q <= dm_gnt_s & misalign_s;
    end
  end

  assign if_rdata_o = if_rdata_q;
  assign dm_rdata_o = dm_rdata_q;
  assign dm_err_o   = dm_err_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench: directed vector table, reset/starvation sequences,
// then random traffic against a behavioural model of the arbiter.
module tb_imem_port_arbiter;

  localparam int ADDR_W     = 6;
  localparam int STARVE_MAX = 3;
  localparam int MEM_BYTES  = 1 << (ADDR_W + 2);
  localparam int WORDS      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req = 1'b0;
  logic [31:0]       if_addr = 32'h0;
  logic              dm_req = 1'b0;
  logic              dm_we = 1'b0;
  logic [3:0]        dm_be = 4'h0;
  logic [31:0]       dm_addr = 32'h0;
  logic [31:0]       dm_wdata = 32'h0;
  logic              if_gnt, if_rvalid, stall_if, dm_gnt, dm_rvalid, dm_err, mem_we;
  logic [31:0]       if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;

  logic [31:0] tb_mem  [WORDS];
  logic [31:0] ref_mem [WORDS];

  int n_cmp = 0;
  int n_bad = 0;

  imem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .stall_if_o(stall_if),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
    .dm_wdata_i(dm_wdata), .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid),
    .dm_rdata_o(dm_rdata), .dm_err_o(dm_err),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory array the DUT drives
  assign mem_rdata = tb_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        dmr, dmwe;
    logic [3:0]  dmbe;
    logic [31:0] dma, dmwd;
    logic        x_ifg, x_dmg, x_stall;
    logic [5:0]  x_maddr;
    logic        x_mwe, x_ifrv;
    logic [31:0] x_ifrd;
    logic        x_dmrv;
    logic [31:0] x_dmrd;
    logic        x_dmerr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic r, ifr, input logic [31:0] ifa,
    input logic dmr, dmwe, input logic [3:0] dmbe, input logic [31:0] dma, dmwd,
    input logic ifg, dmg, stl, input logic [5:0] ma, input logic mwe,
    input logic ifrv, input logic [31:0] ifrd, input logic dmrv,
    input logic [31:0] dmrd, input logic dmerr);
    vec_t v;
    v = '{r, ifr, ifa, dmr, dmwe, dmbe, dma, dmwd, ifg, dmg, stl, ma, mwe,
          ifrv, ifrd, dmrv, dmrd, dmerr};
    tbl.push_back(v);
  endfunction

  // Behavioural model state
  int          streak;
  logic        e_if_rv, e_dm_rv, e_dm_err;
  logic [31:0] e_if_rd, e_dm_rd;

  function automatic int widx(input logic [31:0] a);
    return int'(a % MEM_BYTES) / 4;
  endfunction

  task automatic drive(input logic r, ifr, input logic [31:0] ifa, input logic dmr,
                       dmwe, input logic [3:0] dmbe, input logic [31:0] dma, dmwd);
    rst = r; if_req = ifr; if_addr = ifa; dm_req = dmr; dm_we = dmwe;
    dm_be = dmbe; dm_addr = dma; dm_wdata = dmwd;
  endtask

  initial begin
    logic dmw, ifw, xwe, pend_if, pend_dm;
    int   xaddr;

    for (int i = 0; i < WORDS; i++) tb_mem[i] = 32'hA000_0000 | 32'(i);
    tb_mem[1] = 32'h0010_0093;

    //  rst ifr ifa      dmr we be    dma      wdata        | ifg dmg stl ma we | ifrv ifrd        dmrv dmrd        err
    add(1, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 6'd0, 0,  0, 32'h0,        0, 32'h0,        0);
    add(1, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 6'd0, 0,  0, 32'h0,        0, 32'h0,        0);
    add(0, 1, 32'h4,   0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 0, 6'd1, 0,  1, 32'h00100093, 0, 32'h0,        0);
    add(0, 1, 32'h8,   1, 0, 4'hF, 32'h10, 32'h0,        0, 1, 1, 6'd4, 0,  0, 32'h00100093, 1, 32'hA0000004, 0);
    add(0, 1, 32'h8,   1, 0, 4'hF, 32'h10, 32'h0,        0, 1, 1, 6'd4, 0,  0, 32'h00100093, 1, 32'hA0000004, 0);
    add(0, 1, 32'h8,   1, 0, 4'hF, 32'h10, 32'h0,        0, 1, 1, 6'd4, 0,  0, 32'h00100093, 1, 32'hA0000004, 0);
    add(0, 1, 32'h8,   1, 0, 4'hF, 32'h10, 32'h0,        1, 0, 0, 6'd2, 0,  1, 32'hA0000002, 0, 32'hA0000004, 0);
    add(0, 1, 32'h8,   1, 0, 4'hF, 32'h10, 32'h0,        0, 1, 1, 6'd4, 0,  0, 32'hA0000002, 1, 32'hA0000004, 0);
    add(0, 0, 32'h0,   1, 1, 4'hF, 32'hC,  32'hDEADBEEF, 0, 1, 0, 6'd3, 1,  0, 32'hA0000002, 1, 32'h0,        0);
    add(0, 0, 32'h0,   1, 0, 4'hF, 32'hC,  32'h0,        0, 1, 0, 6'd3, 0,  0, 32'hA0000002, 1, 32'hDEADBEEF, 0);
    add(0, 0, 32'h0,   1, 1, 4'hF, 32'hD,  32'h12345678, 0, 1, 0, 6'd3, 0,  0, 32'hA0000002, 1, 32'h0,        1);
    add(0, 0, 32'h0,   1, 0, 4'hF, 32'hC,  32'h0,        0, 1, 0, 6'd3, 0,  0, 32'hA0000002, 1, 32'hDEADBEEF, 0);
    add(0, 0, 32'h0,   1, 0, 4'hF, 32'h12, 32'h0,        0, 1, 0, 6'd4, 0,  0, 32'hA0000002, 1, 32'hA0000004, 1);
    add(0, 1, 32'h104, 0, 0, 4'h0, 32'h0,  32'h0,        1, 0, 0, 6'd1, 0,  1, 32'h00100093, 0, 32'hA0000004, 0);
    add(0, 0, 32'h0,   1, 1, 4'h3, 32'hC,  32'h0000CAFE, 0, 1, 0, 6'd3, 1,  0, 32'h00100093, 1, 32'h0,        0);
    add(0, 0, 32'h0,   1, 0, 4'hF, 32'hC,  32'h0,        0, 1, 0, 6'd3, 0,  0, 32'h00100093, 1, 32'hDEADCAFE, 0);
    add(0, 0, 32'h0,   0, 0, 4'h0, 32'h0,  32'h0,        0, 0, 0, 6'd0, 0,  0, 32'h00100093, 0, 32'hDEADCAFE, 0);

    #1;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ifr, tbl[i].ifa, tbl[i].dmr, tbl[i].dmwe,
            tbl[i].dmbe, tbl[i].dma, tbl[i].dmwd);
      @(negedge clk);
      chk($sformatf("v%0d if_gnt", i),   32'(if_gnt),   32'(tbl[i].x_ifg));
      chk($sformatf("v%0d dm_gnt", i),   32'(dm_gnt),   32'(tbl[i].x_dmg));
      chk($sformatf("v%0d stall_if", i), 32'(stall_if), 32'(tbl[i].x_stall));
      chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].x_maddr));
      chk($sformatf("v%0d mem_we", i),   32'(mem_we),   32'(tbl[i].x_mwe));
      @(posedge clk); #1;
      chk($sformatf("v%0d if_rvalid", i), 32'(if_rvalid), 32'(tbl[i].x_ifrv));
      chk($sformatf("v%0d if_rdata", i),  if_rdata,       tbl[i].x_ifrd);
      chk($sformatf("v%0d dm_rvalid", i), 32'(dm_rvalid), 32'(tbl[i].x_dmrv));
      chk($sformatf("v%0d dm_rdata", i),  dm_rdata,       tbl[i].x_dmrd);
      chk($sformatf("v%0d dm_err", i),    32'(dm_err),    32'(tbl[i].x_dmerr));
    end

    // Reset while a data access is in flight, after fetch has starved twice
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0);
      @(posedge clk); #1;
    end
    drive(1, 1, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0);
    @(negedge clk);
    chk("rstmid dm_gnt", 32'(dm_gnt), 32'd1);
    @(posedge clk); #1;
    chk("rstmid dm_rvalid N+1", 32'(dm_rvalid), 32'd0);
    chk("rstmid dm_rdata", dm_rdata, 32'h0);
    chk("rstmid if_rdata", if_rdata, 32'h0);
    drive(0, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("rstmid dm_rvalid N+2", 32'(dm_rvalid), 32'd0);
    chk("rstmid if_rvalid N+2", 32'(if_rvalid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h0, 1, 0, 4'hF, 32'h14, 32'h0);
      @(negedge clk);
      chk($sformatf("post-rst starve c%0d if_gnt", k), 32'(if_gnt), (k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("post-rst starve c%0d dm_gnt", k), 32'(dm_gnt), (k == 3) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
    end

    // Random traffic against the model, starting from a clean reset
    drive(1, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = tb_mem[i];
    streak = 0; e_if_rv = 0; e_dm_rv = 0; e_dm_err = 0; e_if_rd = 32'h0; e_dm_rd = 32'h0;
    pend_if = 1'b0; pend_dm = 1'b0;
    rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      if (!pend_if) begin
        if_req  = ($urandom_range(0, 9) < 7);
        if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!pend_dm) begin
        dm_req   = ($urandom_range(0, 9) < 6);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_be    = 4'($urandom_range(0, 15));
        dm_addr  = $urandom();
        if ($urandom_range(0, 3) != 0) dm_addr[1:0] = 2'b00;
        dm_wdata = $urandom();
      end
      rst = ($urandom_range(0, 199) == 0);

      @(negedge clk);
      dmw   = dm_req && !(if_req && streak >= STARVE_MAX);
      ifw   = if_req && !dmw;
      xaddr = ifw ? widx(if_addr) : (dmw ? widx(dm_addr) : 0);
      xwe   = dmw && dm_we && (dm_addr % 4 == 0);
      chk("rnd if_gnt",    32'(if_gnt),    32'(ifw));
      chk("rnd dm_gnt",    32'(dm_gnt),    32'(dmw));
      chk("rnd stall_if",  32'(stall_if),  32'(if_req && !ifw));
      chk("rnd mem_addr",  32'(mem_addr),  32'(xaddr));
      chk("rnd mem_we",    32'(mem_we),    32'(xwe));
      chk("rnd if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      chk("rnd if_rdata",  if_rdata,       e_if_rd);
      chk("rnd dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
      chk("rnd dm_rdata",  dm_rdata,       e_dm_rd);
      chk("rnd dm_err",    32'(dm_err),    32'(e_dm_err));

      if (rst) begin
        streak = 0; e_if_rv = 0; e_dm_rv = 0; e_dm_err = 0;
        e_if_rd = 32'h0; e_dm_rd = 32'h0;
      end else begin
        e_if_rv  = ifw;
        e_dm_rv  = dmw;
        e_dm_err = dmw && (dm_addr % 4 != 0);
        if (ifw) e_if_rd = ref_mem[widx(if_addr)];
        if (dmw) e_dm_rd = dm_we ? 32'h0 : ref_mem[widx(dm_addr)];
        streak = (if_req && !ifw) ? ((streak < STARVE_MAX) ? streak + 1 : STARVE_MAX) : 0;
      end
      if (xwe) begin
        for (int b = 0; b < 4; b++) begin
          if (dm_be[b]) ref_mem[widx(dm_addr)][8*b +: 8] = dm_wdata[8*b +: 8];
        end
      end
      pend_if = if_req && !ifw;
      pend_dm = dm_req && !dmw;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
